// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - RV32I opcodes, immediate formats and opcode-class helpers
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: return IMM_I;
            OPC_STORE:                      return IMM_S;
            OPC_BRANCH:                     return IMM_B;
            OPC_LUI, OPC_AUIPC:             return IMM_U;
            OPC_JAL:                        return IMM_J;
            default:                        return IMM_NONE;
        endcase
    endfunction

    function automatic logic writes_rd(input logic [6:0] opcode);
        case (opcode)
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI,
            OPC_AUIPC, OPC_JAL, OPC_JALR: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs1(input logic [6:0] opcode);
        case (opcode)
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE,
            OPC_BRANCH, OPC_JALR: return 1'b1;
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        case (opcode)
            OPC_OP, OPC_STORE, OPC_BRANCH: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational sign-extended immediate decode for RV32I
module imm_gen
    import rv32_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (imm_fmt_of(instr[6:0]))
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - decode/operand-fetch stage with hazard scoreboard
// OPFETCH_BYPASS_EN selects same-cycle writeback bypass; otherwise a writeback match stalls one cycle.
module operand_fetch #(
    parameter int XLEN = rv32_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [31:0]     in_pc,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    input  logic [XLEN-1:0] rs1_value,
    input  logic [XLEN-1:0] rs2_value,
    input  logic            wb_regwrite,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_value,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_pc,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd
);
    import rv32_pkg::*;

    logic            valid_q, valid_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] op1_q, op1_d;
    logic [XLEN-1:0] op2_q, op2_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [4:0]      rd_q, rd_d;
    logic [31:1]     pending_q, pending_d;

    logic [6:0]  opcode;
    logic [4:0]  src1, src2, dst;
    logic [31:0] pend_full, wb_clr, pend_next;
    logic [31:0] imm;
    logic        hazard, fire;
    logic        src1_wb, src2_wb, dst_wb;
    logic [XLEN-1:0] op1_sel, op2_sel;

    imm_gen u_imm_gen (
        .instr (in_instr),
        .imm   (imm)
    );

    assign opcode = in_instr[6:0];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];

    // Unused sources collapse to x0 so they never match the scoreboard or writeback.
    assign src1 = uses_rs1(opcode)  ? rs1 : 5'd0;
    assign src2 = uses_rs2(opcode)  ? rs2 : 5'd0;
    assign dst  = writes_rd(opcode) ? in_instr[11:7] : 5'd0;

    assign pend_full = {pending_q, 1'b0};
    assign wb_clr    = (wb_regwrite && wb_rd != 5'd0) ? (32'd1 << wb_rd) : 32'd0;

    assign src1_wb = wb_clr[src1];
    assign src2_wb = wb_clr[src2];
    assign dst_wb  = wb_clr[dst];

    always_comb begin
        hazard = (pend_full[src1] && !src1_wb)
              || (pend_full[src2] && !src2_wb)
              || (pend_full[dst]  && !dst_wb);
`ifndef OPFETCH_BYPASS_EN
        hazard = hazard || src1_wb || src2_wb || dst_wb;
`endif
    end

    assign in_ready = !hazard && (!valid_q || out_ready);
    assign fire     = in_valid && in_ready;

`ifdef OPFETCH_BYPASS_EN
    assign op1_sel = (src1 == 5'd0) ? '0 : (src1_wb ? wb_value : rs1_value);
    assign op2_sel = (src2 == 5'd0) ? '0 : (src2_wb ? wb_value : rs2_value);
`else
    logic unused_wb_value;
    assign unused_wb_value = ^wb_value;
    assign op1_sel = (src1 == 5'd0) ? '0 : rs1_value;
    assign op2_sel = (src2 == 5'd0) ? '0 : rs2_value;
`endif

    // Clear first, then set, so an issuing instruction reclaims a register retiring this cycle.
    always_comb begin
        pend_next = pend_full & ~wb_clr;
        if (fire && dst != 5'd0) begin
            pend_next = pend_next | (32'd1 << dst);
        end
        pending_d = pend_next[31:1];
    end

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        imm_d   = imm_q;
        rd_d    = rd_q;
        if (fire) begin
            valid_d = 1'b1;
            pc_d    = in_pc;
            instr_d = in_instr;
            op1_d   = op1_sel;
            op2_d   = op2_sel;
            imm_d   = imm;
            rd_d    = dst;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            instr_q   <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            imm_q     <= '0;
            rd_q      <= '0;
            pending_q <= '0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            imm_q     <= imm_d;
            rd_q      <= rd_d;
            pending_q <= pending_d;
        end
    end

    assign out_valid = valid_q;
    assign out_pc    = pc_q;
    assign out_instr = instr_q;
    assign out_op1   = op1_q;
    assign out_op2   = op2_q;
    assign out_imm   = imm_q;
    assign out_rd    = rd_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed self-checking bench for operand_fetch
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rs1, rs2;
    logic [31:0] rs1_value, rs2_value;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_value;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc, out_instr, out_op1, out_op2, out_imm;
    logic [4:0]  out_rd;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] regs [32] = '{default: 32'd0};

    operand_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_value   (rs1_value),
        .rs2_value   (rs2_value),
        .wb_regwrite (wb_regwrite),
        .wb_rd       (wb_rd),
        .wb_value    (wb_value),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .out_op1     (out_op1),
        .out_op2     (out_op2),
        .out_imm     (out_imm),
        .out_rd      (out_rd)
    );

    always #5 clk = ~clk;

    // Register bank model: combinational read, write on the clock edge.
    assign rs1_value = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_value = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
    always @(posedge clk) begin
        if (wb_regwrite && wb_rd != 5'd0) regs[wb_rd] <= wb_value;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid    = 1'b0;
        wb_regwrite = 1'b0;
        wb_rd       = 5'd0;
        wb_value    = 32'd0;
        out_ready   = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        in_instr = 32'd0;
        in_pc    = 32'd0;
        rst      = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [31:0] v);
        wb_regwrite = 1'b1;
        wb_rd       = r;
        wb_value    = v;
        tick();
        wb_regwrite = 1'b0;
        wb_rd       = 5'd0;
    endtask

    logic [31:0] imm_instr [6] = '{32'h12345037, 32'hFFDFF06F, 32'hFE000CE3,
                                    32'h0000007F, 32'h00000033, 32'h80000017};
    logic [31:0] imm_exp   [6] = '{32'h12345000, 32'hFFFFFFFC, 32'hFFFFFFF8,
                                    32'h00000000, 32'h00000000, 32'h80000000};

    initial begin
        // Reset state
        do_reset();
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out_imm", out_imm, 32'd0);
        check("reset pending", {dut.pending_q, 1'b0}, 32'd0);

        // add x4,x3,x0 while x3 is being written back
        in_instr    = 32'h00018233;
        in_pc       = 32'h00001000;
        in_valid    = 1'b1;
        wb_regwrite = 1'b1;
        wb_rd       = 5'd3;
        wb_value    = 32'hDEADBEEF;
`ifdef OPFETCH_BYPASS_EN
        #1 check("bypass in_ready", {31'd0, in_ready}, 32'd1);
        tick();
`else
        #1 check("wb-match stall", {31'd0, in_ready}, 32'd0);
        tick();
        wb_regwrite = 1'b0;
        #1 check("wb-match release", {31'd0, in_ready}, 32'd1);
        tick();
`endif
        idle();
        check("bypass out_valid", {31'd0, out_valid}, 32'd1);
        check("bypass out_op1", out_op1, 32'hDEADBEEF);
        check("bypass out_rd", {27'd0, out_rd}, 32'd4);
        check("bypass out_pc", out_pc, 32'h00001000);
        check("bypass pending", {dut.pending_q, 1'b0}, 32'h00000010);

        // Load-use: lw x5,0(x1) then add x6,x5,x0
        do_reset();
        wb_write(5'd1, 32'h00000100);
        in_instr = 32'h0000A283;
        in_pc    = 32'h00002000;
        in_valid = 1'b1;
        #1 check("lw in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("lw out_rd", {27'd0, out_rd}, 32'd5);
        check("lw out_op1", out_op1, 32'h00000100);
        in_instr = 32'h00028333;
        in_pc    = 32'h00002004;
        #1 check("raw stall 1", {31'd0, in_ready}, 32'd0);
        tick();
        check("raw drained out_valid", {31'd0, out_valid}, 32'd0);
        check("raw stall 2", {31'd0, in_ready}, 32'd0);
        wb_regwrite = 1'b1;
        wb_rd       = 5'd5;
        wb_value    = 32'h12345678;
`ifdef OPFETCH_BYPASS_EN
        #1 check("raw wb unblock", {31'd0, in_ready}, 32'd1);
        tick();
`else
        #1 check("raw wb stall", {31'd0, in_ready}, 32'd0);
        tick();
        wb_regwrite = 1'b0;
        #1 check("raw wb unblock", {31'd0, in_ready}, 32'd1);
        tick();
`endif
        idle();
        check("raw out_valid", {31'd0, out_valid}, 32'd1);
        check("raw out_op1", out_op1, 32'h12345678);
        check("raw out_rd", {27'd0, out_rd}, 32'd6);
        check("raw pending", {dut.pending_q, 1'b0}, 32'h00000040);

        // Store immediate: sw x2,-4(x1)
        do_reset();
        wb_write(5'd1, 32'h00000100);
        wb_write(5'd2, 32'h0000CAFE);
        in_instr = 32'hFE20AE23;
        in_valid = 1'b1;
        #1 check("sw in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        idle();
        check("sw out_imm", out_imm, 32'hFFFFFFFC);
        check("sw out_rd", {27'd0, out_rd}, 32'd0);
        check("sw out_op1", out_op1, 32'h00000100);
        check("sw out_op2", out_op2, 32'h0000CAFE);
        check("sw pending", {dut.pending_q, 1'b0}, 32'd0);

        // Immediate formats back to back, rd = x0
        do_reset();
        for (int i = 0; i < 6; i++) begin
            in_instr = imm_instr[i];
            in_valid = 1'b1;
            #1 check($sformatf("imm%0d in_ready", i), {31'd0, in_ready}, 32'd1);
            tick();
            check($sformatf("imm%0d out_imm", i), out_imm, imm_exp[i]);
            check($sformatf("imm%0d out_rd", i), {27'd0, out_rd}, 32'd0);
        end
        idle();

        // addi x0,x0,5 three times back to back
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_instr = 32'h00500013;
            in_valid = 1'b1;
            #1 check($sformatf("x0dst%0d in_ready", i), {31'd0, in_ready}, 32'd1);
            tick();
            check($sformatf("x0dst%0d out_imm", i), out_imm, 32'd5);
        end
        idle();
        check("x0dst pending", {dut.pending_q, 1'b0}, 32'd0);

        // Backpressure: hold addi x7 while addi x8 waits
        do_reset();
        in_instr = 32'h00100393;
        in_pc    = 32'h00003000;
        in_valid = 1'b1;
        tick();
        out_ready = 1'b0;
        in_instr  = 32'h00200413;
        in_pc     = 32'h00003004;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("bp%0d in_ready", i), {31'd0, in_ready}, 32'd0);
            tick();
            check($sformatf("bp%0d out_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp%0d out_rd", i), {27'd0, out_rd}, 32'd7);
            check($sformatf("bp%0d out_imm", i), out_imm, 32'd1);
            check($sformatf("bp%0d out_pc", i), out_pc, 32'h00003000);
        end
        out_ready = 1'b1;
        #1 check("bp release in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("bp release out_rd", {27'd0, out_rd}, 32'd8);
        check("bp release out_imm", out_imm, 32'd2);
        check("bp release out_pc", out_pc, 32'h00003004);
        check("bp pending", {dut.pending_q, 1'b0}, 32'h00000180);

        // Asynchronous reset mid-transfer drops the bundle and scoreboard
        out_ready = 1'b0;
        in_instr  = 32'h00300493;
        #2 rst = 1'b1;
        #1;
        check("midrst out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst out_rd", {27'd0, out_rd}, 32'd0);
        check("midrst pending", {dut.pending_q, 1'b0}, 32'd0);
        tick();
        rst = 1'b0;
        idle();
        #1 check("midrst in_ready", {31'd0, in_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
